reg_file_wb: RTL
================

// Module: reg_file_wb
// PURPOSE
//  MIPS 32x32 general-purpose register file; consumer end of the RegDst destination-select path.
//  Accepts the 5-bit write address chosen upstream (rt/rd), commits write-back data on the clock edge,
//  and serves two combinational read ports (rs, rt) plus a debug read port for the display/test harness.
//  Keeps a saturating retired-write counter and last-written-address tag for debug.
// PARAMETERS
//  DATA_W   32   register width in bits
//  ADDR_W   5    register index width; register count = 2**ADDR_W
//  CNT_W    16   width of write counter
// PORTS
//  clk        in   1        rising-edge clock, single clock domain
//  rst_n      in   1        asynchronous, active-low reset
//  rs_addr    in   ADDR_W   read port A index
//  rt_addr    in   ADDR_W   read port B index
//  rs_data    out  DATA_W   read port A data (combinational)
//  rt_data    out  DATA_W   read port B data (combinational)
//  wr_en      in   1        write-back enable (RegWrite)
//  wr_addr    in   ADDR_W   write index (RegDst mux output)
//  wr_data    in   DATA_W   write-back data
//  dbg_addr   in   ADDR_W   debug read index
//  dbg_data   out  DATA_W   debug read data (combinational)
//  wr_cnt     out  CNT_W    count of committed writes, saturating
//  last_wr    out  ADDR_W   index of most recent committed write
// BEHAVIOUR
//  Reset (rst_n=0, async, any time): all registers <= 0, wr_cnt <= 0, last_wr <= 0; held while low.
//  Mid-cycle reset discards any pending write; first write accepted on first rising edge with rst_n=1.
//  Commit: on posedge clk, if wr_en && wr_addr!=0 -> reg[wr_addr] <= wr_data; wr_cnt += 1 unless
//   all-ones (saturate, no wrap); last_wr <= wr_addr. Latency: value readable the cycle after the edge.
//  Register 0: reads always return 0; writes to index 0 ignored, do not count, do not update last_wr.
//  Reads: rs_data/rt_data/dbg_data = reg[addr] combinationally; 0 for index 0.
//  Same-cycle read of register being written: governed by REGFILE_BYPASS_EN (below).
//  rs_addr==rt_addr legal; both ports return identical data.
//  wr_en=0: no state changes regardless of wr_addr/wr_data (X on those inputs must not propagate).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-first. If wr_en && wr_addr!=0 && wr_addr==rs_addr (resp. rt_addr),
//   rs_data (resp. rt_data) = wr_data in the same cycle. dbg_data never bypasses.
//  Undefined: read-first. Read ports return pre-edge stored value; new value visible next cycle.
// STRUCTURE
//  Shared package mips_defs_pkg: REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0.
//  No sub-module; storage array, counter and bypass muxes live in this module.
// TESTING
//  1 Reset: rst_n=0 then 1; read all 32 indices via rs/rt/dbg -> all 0; wr_cnt=0, last_wr=0.
//  2 Write/read: wr_en=1, wr_addr=5'd8, wr_data=32'hDEADBEEF; next cycle rs_addr=8 -> DEADBEEF;
//    wr_cnt=1, last_wr=8.
//  3 Zero reg: wr_en=1, wr_addr=0, wr_data=32'hFFFFFFFF -> rs_data@0 stays 0; wr_cnt, last_wr unchanged.
//  4 Same-cycle hazard: reg[9]=32'h1; wr_addr=9, wr_data=32'h2, rs_addr=9 in that cycle ->
//    rs_data=2 with REGFILE_BYPASS_EN, 1 without; both 2 next cycle.
//  5 Saturation: force 65535 writes (CNT_W=16) then one more to index 3 -> wr_cnt stays 16'hFFFF,
//    reg[3] still updates.
//  6 Async reset mid-run: populate regs 1..31, assert rst_n low between edges -> outputs 0 immediately,
//    no write on the next edge while low.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS datapath definitions: register-file geometry and the hard-wired zero index.
package mips_defs_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_file_wb.sv
// MIPS 32x32 register file: write-back on posedge, 3 combinational read ports, saturating write counter.
// Write visible one cycle after the edge; REGFILE_BYPASS_EN selects write-first on rs/rt. No backpressure.
module reg_file_wb
  import mips_defs_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [ADDR_W-1:0] last_wr
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] last_wr_q, last_wr_d;
  logic              commit;
  logic [DATA_W-1:0] rs_stored, rt_stored;

  // Gating on rst_n keeps the bypass path quiet while reset is held.
  assign commit = rst_n && wr_en && (wr_addr != ZERO_IDX);

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    last_wr_d = last_wr_q;
    if (commit) begin
      wr_cnt_d  = (&wr_cnt_q) ? wr_cnt_q : wr_cnt_q + CNT_W'(1);
      last_wr_d = wr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      wr_cnt_q  <= '0;
      last_wr_q <= '0;
    end else begin
      if (commit) regs_q[wr_addr] <= wr_data;
      wr_cnt_q  <= wr_cnt_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign rs_stored = (rs_addr == ZERO_IDX) ? '0 : regs_q[rs_addr];
  assign rt_stored = (rt_addr == ZERO_IDX) ? '0 : regs_q[rt_addr];
  assign dbg_data  = (dbg_addr == ZERO_IDX) ? '0 : regs_q[dbg_addr];

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rs_data = rs_stored;
    rt_data = rt_stored;
    if (commit && (wr_addr == rs_addr)) rs_data = wr_data;
    if (commit && (wr_addr == rt_addr)) rt_data = wr_data;
  end
`else
  assign rs_data = rs_stored;
  assign rt_data = rt_stored;
`endif

  assign wr_cnt  = wr_cnt_q;
  assign last_wr = last_wr_q;

endmodule
